// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: command payload, FSM state encoding and bus widths.
package i2c_seq_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_RESP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO of cmd_t; pointers carry an extra wrap bit to tell full from empty.
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  cmd_t                       push_data,
    input  logic                       pop,
    output cmd_t                       pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    always_comb begin
        push_ok_c = push & ~full;
        pop_ok_c  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q + (PTR_W + 1)'(push_ok_c);
        rd_ptr_d  = rd_ptr_q + (PTR_W + 1)'(pop_ok_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign level    = LVL_W'(wr_ptr_q - rd_ptr_q);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command stage in front of the I2C master: queues commands, issues one at a time, returns in-order responses.
// Optional WAIT-state watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rw,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       mst_en,
    output logic                       mst_rw,
    output logic [ADDR_W-1:0]          mst_addr,
    output logic [DATA_W-1:0]          mst_wdata,
    input  logic [DATA_W-1:0]          mst_rdata,
    input  logic                       mst_done,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_rw,
    output logic [ADDR_W-1:0]          rsp_addr,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam logic [1:0] ST_IDLE  = SEQ_IDLE;
    localparam logic [1:0] ST_ISSUE = SEQ_ISSUE;
    localparam logic [1:0] ST_WAIT  = SEQ_WAIT;
    localparam logic [1:0] ST_RESP  = SEQ_RESP;

    logic [1:0]        state_q, state_d;
    logic              done_q;
    logic              done_edge_c;
    logic              pop_c;
    logic              fifo_full, fifo_empty;
    cmd_t              head;
    cmd_t              cmd_in;

    logic              mst_en_q, mst_en_d;
    logic              mst_rw_q, mst_rw_d;
    logic [ADDR_W-1:0] mst_addr_q, mst_addr_d;
    logic [DATA_W-1:0] mst_wdata_q, mst_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_rw_q, rsp_rw_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              busy_q, busy_d;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              rsp_err_q, rsp_err_d;
`else
    logic              unused_timeout_c;
    assign unused_timeout_c = ^32'(TIMEOUT_CYCLES);
`endif

    assign cmd_ready   = ~fifo_full;
    assign cmd_in      = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
    assign done_edge_c = mst_done & ~done_q;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid & cmd_ready),
        .push_data (cmd_in),
        .pop       (pop_c),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Next-state and output decode; mst_en_d anticipates the ISSUE cycle so the pulse is registered.
    always_comb begin
        state_d     = state_q;
        pop_c       = 1'b0;
        mst_en_d    = 1'b0;
        mst_rw_d    = mst_rw_q;
        mst_addr_d  = mst_addr_q;
        mst_wdata_d = mst_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rw_d    = rsp_rw_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        wdog_d      = wdog_q;
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c       = 1'b1;
                    mst_rw_d    = head.rw;
                    mst_addr_d  = head.addr;
                    mst_wdata_d = head.wdata;
                    mst_en_d    = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_edge_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_rw_d    = mst_rw_q;
                    rsp_addr_d  = mst_addr_q;
                    rsp_rdata_d = mst_rw_q ? mst_rdata : '0;
`ifdef I2C_SEQ_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = ST_RESP;
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_rw_d    = mst_rw_q;
                    rsp_addr_d  = mst_addr_q;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            mst_en_q    <= 1'b0;
            mst_rw_q    <= 1'b0;
            mst_addr_q  <= '0;
            mst_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rw_q    <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= mst_done;
            mst_en_q    <= mst_en_d;
            mst_rw_q    <= mst_rw_d;
            mst_addr_q  <= mst_addr_d;
            mst_wdata_q <= mst_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rw_q    <= rsp_rw_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign mst_en    = mst_en_q;
    assign mst_rw    = mst_rw_q;
    assign mst_addr  = mst_addr_q;
    assign mst_wdata = mst_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rw    = rsp_rw_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

endmodule
